// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: operand forwarding,
// load-use bubble insertion, stall and flush handling.
module id_ex_stage #(
  parameter int unsigned XLEN         = 32,
  parameter bit          NOP_ON_FLUSH = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc4_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm32_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic [2:0]      id_funct3_i,
  input  logic [6:0]      id_funct7_i,
  input  logic            id_alusrc_i,
  input  logic [1:0]      id_aluop_i,
  input  logic [1:0]      id_utype_i,
  input  logic            id_regwrite_i,
  input  logic            id_memread_i,
  input  logic            id_memwrite_i,
  input  logic            id_memtoreg_i,
  input  logic            id_branch_i,
  input  logic            exmem_regwrite_i,
  input  logic [4:0]      exmem_rd_i,
  input  logic [XLEN-1:0] exmem_result_i,
  input  logic            memwb_regwrite_i,
  input  logic [4:0]      memwb_rd_i,
  input  logic [XLEN-1:0] memwb_result_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc4_o,
  output logic [XLEN-1:0] ex_imm32_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [4:0]      ex_rd_o,
  output logic [2:0]      ex_funct3_o,
  output logic [6:0]      ex_funct7_o,
  output logic            ex_alusrc_o,
  output logic [1:0]      ex_aluop_o,
  output logic [1:0]      ex_utype_o,
  output logic            ex_regwrite_o,
  output logic            ex_memread_o,
  output logic            ex_memwrite_o,
  output logic            ex_memtoreg_o,
  output logic            ex_branch_o,
  output logic            load_use_stall_o
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm32;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            alusrc;
    logic [1:0]      aluop;
    logic [1:0]      utype;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            branch;
  } id_ex_t;

  id_ex_t          r_q;
  id_ex_t          w_d;
  id_ex_t          w_in;
  id_ex_t          w_bubble;
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;
  logic            w_lu;

  always_comb begin
    w_in          = '0;
    w_in.valid    = id_valid_i;
    w_in.pc4      = id_pc4_i;
    w_in.rs1_data = id_rs1_data_i;
    w_in.rs2_data = id_rs2_data_i;
    w_in.imm32    = id_imm32_i;
    w_in.rs1      = id_rs1_i;
    w_in.rs2      = id_rs2_i;
    w_in.rd       = id_rd_i;
    w_in.funct3   = id_funct3_i;
    w_in.funct7   = id_funct7_i;
    w_in.alusrc   = id_alusrc_i;
    w_in.aluop    = id_aluop_i;
    w_in.utype    = id_utype_i;
    w_in.regwrite = id_regwrite_i;
    w_in.memread  = id_memread_i;
    w_in.memwrite = id_memwrite_i;
    w_in.memtoreg = id_memtoreg_i;
    w_in.branch   = id_branch_i;
  end

  // Bubble keeps the held data fields when only controls are cleared
  always_comb begin
    w_bubble = NOP_ON_FLUSH ? '0 : r_q;
    w_bubble.valid    = 1'b0;
    w_bubble.alusrc   = 1'b0;
    w_bubble.aluop    = 2'b00;
    w_bubble.utype    = 2'b00;
    w_bubble.regwrite = 1'b0;
    w_bubble.memread  = 1'b0;
    w_bubble.memwrite = 1'b0;
    w_bubble.memtoreg = 1'b0;
    w_bubble.branch   = 1'b0;
  end

  always_comb begin
    w_fwd1 = r_q.rs1_data;
    if (exmem_regwrite_i && exmem_rd_i != 5'd0
        && exmem_rd_i == r_q.rs1)
      w_fwd1 = exmem_result_i;
    else if (memwb_regwrite_i && memwb_rd_i != 5'd0
             && memwb_rd_i == r_q.rs1)
      w_fwd1 = memwb_result_i;
  end

  always_comb begin
    w_fwd2 = r_q.rs2_data;
    if (exmem_regwrite_i && exmem_rd_i != 5'd0
        && exmem_rd_i == r_q.rs2)
      w_fwd2 = exmem_result_i;
    else if (memwb_regwrite_i && memwb_rd_i != 5'd0
             && memwb_rd_i == r_q.rs2)
      w_fwd2 = memwb_result_i;
  end

  always_comb begin
    w_lu = !flush_i && r_q.valid && r_q.memread
           && r_q.rd != 5'd0 && id_valid_i
           && (r_q.rd == id_rs1_i || r_q.rd == id_rs2_i);
  end

  // Operands recapture under stall so a retiring producer is not lost
  always_comb begin
    w_d = w_in;
    if (flush_i) begin
      w_d = w_bubble;
    end else if (stall_i) begin
      w_d          = r_q;
      w_d.rs1_data = w_fwd1;
      w_d.rs2_data = w_fwd2;
    end else if (w_lu) begin
      w_d = w_bubble;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= w_d;
  end

  assign ex_valid_o       = r_q.valid;
  assign ex_pc4_o         = r_q.pc4;
  assign ex_imm32_o       = r_q.imm32;
  assign ex_rs1_data_o    = w_fwd1;
  assign ex_rs2_data_o    = w_fwd2;
  assign ex_rd_o          = r_q.rd;
  assign ex_funct3_o      = r_q.funct3;
  assign ex_funct7_o      = r_q.funct7;
  assign ex_alusrc_o      = r_q.alusrc;
  assign ex_aluop_o       = r_q.aluop;
  assign ex_utype_o       = r_q.utype;
  assign ex_regwrite_o    = r_q.regwrite;
  assign ex_memread_o     = r_q.memread;
  assign ex_memwrite_o    = r_q.memwrite;
  assign ex_memtoreg_o    = r_q.memtoreg;
  assign ex_branch_o      = r_q.branch;
  assign load_use_stall_o = w_lu;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, forwarding,
// load-use, stall recapture, flush priority, async reset.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_i, flush_i;
  logic        id_valid_i;
  logic [31:0] id_pc4_i, id_rs1_data_i, id_rs2_data_i, id_imm32_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [2:0]  id_funct3_i;
  logic [6:0]  id_funct7_i;
  logic        id_alusrc_i;
  logic [1:0]  id_aluop_i, id_utype_i;
  logic        id_regwrite_i, id_memread_i, id_memwrite_i;
  logic        id_memtoreg_i, id_branch_i;
  logic        exmem_regwrite_i;
  logic [4:0]  exmem_rd_i;
  logic [31:0] exmem_result_i;
  logic        memwb_regwrite_i;
  logic [4:0]  memwb_rd_i;
  logic [31:0] memwb_result_i;
  logic        ex_valid_o;
  logic [31:0] ex_pc4_o, ex_imm32_o, ex_rs1_data_o, ex_rs2_data_o;
  logic [4:0]  ex_rd_o;
  logic [2:0]  ex_funct3_o;
  logic [6:0]  ex_funct7_o;
  logic        ex_alusrc_o;
  logic [1:0]  ex_aluop_o, ex_utype_o;
  logic        ex_regwrite_o, ex_memread_o, ex_memwrite_o;
  logic        ex_memtoreg_o, ex_branch_o;
  logic        load_use_stall_o;

  int n_vec = 0;
  int n_err = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_pc4_i(id_pc4_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm32_i(id_imm32_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_funct3_i(id_funct3_i), .id_funct7_i(id_funct7_i),
    .id_alusrc_i(id_alusrc_i), .id_aluop_i(id_aluop_i),
    .id_utype_i(id_utype_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .id_memwrite_i(id_memwrite_i), .id_memtoreg_i(id_memtoreg_i),
    .id_branch_i(id_branch_i),
    .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i),
    .exmem_result_i(exmem_result_i),
    .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i),
    .memwb_result_i(memwb_result_i),
    .ex_valid_o(ex_valid_o), .ex_pc4_o(ex_pc4_o),
    .ex_imm32_o(ex_imm32_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_rd_o(ex_rd_o),
    .ex_funct3_o(ex_funct3_o), .ex_funct7_o(ex_funct7_o),
    .ex_alusrc_o(ex_alusrc_o), .ex_aluop_o(ex_aluop_o),
    .ex_utype_o(ex_utype_o),
    .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o),
    .ex_memwrite_o(ex_memwrite_o), .ex_memtoreg_o(ex_memtoreg_o),
    .ex_branch_o(ex_branch_o),
    .load_use_stall_o(load_use_stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    id_valid_i = 0; id_pc4_i = 0;
    id_rs1_data_i = 0; id_rs2_data_i = 0; id_imm32_i = 0;
    id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0;
    id_funct3_i = 0; id_funct7_i = 0;
    id_alusrc_i = 0; id_aluop_i = 0; id_utype_i = 0;
    id_regwrite_i = 0; id_memread_i = 0; id_memwrite_i = 0;
    id_memtoreg_i = 0; id_branch_i = 0;
  endtask

  task automatic clr_fwd();
    exmem_regwrite_i = 0; exmem_rd_i = 0; exmem_result_i = 0;
    memwb_regwrite_i = 0; memwb_rd_i = 0; memwb_result_i = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; stall_i = 0; flush_i = 0;
    clr_id(); clr_fwd();
    id_valid_i = 1; id_rd_i = 5; id_imm32_i = 7;
    id_aluop_i = 2'b11; id_alusrc_i = 1; id_regwrite_i = 1;
    id_pc4_i = 32'h104;
    tick(); tick();
    n_vec++;
    if ({ex_valid_o, ex_rd_o, ex_aluop_o, ex_alusrc_o,
         ex_regwrite_o} !== 10'd0 || ex_imm32_o !== 0
        || ex_pc4_o !== 0) begin
      n_err++;
      $display("FAIL reset_regs: valid=%0b rd=%0d imm=%h",
               ex_valid_o, ex_rd_o, ex_imm32_o);
    end
    n_vec++;
    if (ex_rs1_data_o !== 0 || ex_rs2_data_o !== 0
        || load_use_stall_o !== 0) begin
      n_err++;
      $display("FAIL reset_comb: rs1=%h rs2=%h lu=%b want 0",
               ex_rs1_data_o, ex_rs2_data_o, load_use_stall_o);
    end
    rst_n = 1;
    tick();
    n_vec++;
    if (ex_rd_o !== 5 || ex_imm32_o !== 7 || ex_aluop_o !== 2'b11
        || ex_valid_o !== 1 || ex_alusrc_o !== 1
        || ex_pc4_o !== 32'h104 || ex_regwrite_o !== 1) begin
      n_err++;
      $display("FAIL passthru: rd=%0d imm=%h aluop=%b v=%b want 5 7 11 1",
               ex_rd_o, ex_imm32_o, ex_aluop_o, ex_valid_o);
    end
  endtask

  task automatic test_forward();
    clr_id();
    id_valid_i = 1; id_rs1_i = 3; id_rs1_data_i = 32'h11;
    id_rd_i = 6; id_regwrite_i = 1;
    tick();
    exmem_regwrite_i = 1; exmem_rd_i = 3; exmem_result_i = 32'hAA;
    memwb_regwrite_i = 1; memwb_rd_i = 3; memwb_result_i = 32'hBB;
    #1;
    n_vec++;
    if (ex_rs1_data_o !== 32'hAA) begin
      n_err++;
      $display("FAIL fwd_exmem: got %h want aa", ex_rs1_data_o);
    end
    exmem_regwrite_i = 0;
    #1;
    n_vec++;
    if (ex_rs1_data_o !== 32'hBB) begin
      n_err++;
      $display("FAIL fwd_memwb: got %h want bb", ex_rs1_data_o);
    end
    memwb_regwrite_i = 0;
    #1;
    n_vec++;
    if (ex_rs1_data_o !== 32'h11) begin
      n_err++;
      $display("FAIL fwd_none: got %h want 11", ex_rs1_data_o);
    end
    clr_fwd();
    exmem_regwrite_i = 1; exmem_rd_i = 0; exmem_result_i = 32'hFF;
    #1;
    n_vec++;
    if (ex_rs2_data_o !== 32'h0) begin
      n_err++;
      $display("FAIL fwd_x0: got %h want 0", ex_rs2_data_o);
    end
    clr_fwd();
  endtask

  task automatic test_load_use();
    clr_id();
    id_valid_i = 1; id_memread_i = 1; id_regwrite_i = 1;
    id_memtoreg_i = 1; id_rd_i = 7; id_rs1_i = 2; id_funct3_i = 3'b010;
    tick();
    clr_id();
    id_valid_i = 1; id_rs1_i = 7; id_rs2_i = 1; id_rd_i = 8;
    id_regwrite_i = 1; id_rs2_data_i = 32'h5;
    #1;
    n_vec++;
    if (load_use_stall_o !== 1) begin
      n_err++;
      $display("FAIL lu_detect: got %b want 1", load_use_stall_o);
    end
    tick();
    n_vec++;
    if (ex_valid_o !== 0 || ex_regwrite_o !== 0
        || ex_memread_o !== 0 || load_use_stall_o !== 0) begin
      n_err++;
      $display("FAIL lu_bubble: v=%b rw=%b mr=%b lu=%b want 0",
               ex_valid_o, ex_regwrite_o, ex_memread_o,
               load_use_stall_o);
    end
    memwb_regwrite_i = 1; memwb_rd_i = 7; memwb_result_i = 32'h77;
    tick();
    n_vec++;
    if (ex_valid_o !== 1 || ex_rd_o !== 8
        || ex_rs1_data_o !== 32'h77 || ex_rs2_data_o !== 32'h5) begin
      n_err++;
      $display("FAIL lu_replay: v=%b rd=%0d rs1=%h rs2=%h want 1 8 77 5",
               ex_valid_o, ex_rd_o, ex_rs1_data_o, ex_rs2_data_o);
    end
    clr_fwd();
  endtask

  task automatic test_stall_recapture();
    clr_id();
    id_valid_i = 1; id_rs1_i = 4; id_rs1_data_i = 32'h10;
    id_rd_i = 9; id_regwrite_i = 1; id_aluop_i = 2'b10;
    id_funct3_i = 3'b101;
    tick();
    stall_i = 1;
    id_rd_i = 12; id_aluop_i = 2'b01; id_rs1_i = 1;
    memwb_regwrite_i = 1; memwb_rd_i = 4; memwb_result_i = 32'h1234;
    tick();
    clr_fwd();
    for (int c = 2; c <= 3; c++) begin
      n_vec++;
      if (ex_rs1_data_o !== 32'h1234) begin
        n_err++;
        $display("FAIL stall_data cyc%0d: got %h want 1234",
                 c, ex_rs1_data_o);
      end
      n_vec++;
      if (ex_rd_o !== 9 || ex_aluop_o !== 2'b10
          || ex_funct3_o !== 3'b101 || ex_valid_o !== 1) begin
        n_err++;
        $display("FAIL stall_ctrl cyc%0d: rd=%0d aluop=%b f3=%b",
                 c, ex_rd_o, ex_aluop_o, ex_funct3_o);
      end
      tick();
    end
    stall_i = 0;
  endtask

  task automatic test_flush_over_stall();
    clr_id();
    id_valid_i = 1; id_memread_i = 1; id_regwrite_i = 1;
    id_rd_i = 7; id_imm32_i = 32'h20; id_pc4_i = 32'h200;
    tick();
    clr_id();
    id_valid_i = 1; id_rs1_i = 7; id_rd_i = 11; id_regwrite_i = 1;
    flush_i = 1; stall_i = 1;
    #1;
    n_vec++;
    if (load_use_stall_o !== 0) begin
      n_err++;
      $display("FAIL flush_lu: got %b want 0", load_use_stall_o);
    end
    tick();
    n_vec++;
    if (ex_valid_o !== 0 || ex_memread_o !== 0 || ex_regwrite_o !== 0
        || ex_rd_o !== 0 || ex_imm32_o !== 0 || ex_pc4_o !== 0) begin
      n_err++;
      $display("FAIL flush_bubble: v=%b mr=%b rd=%0d imm=%h want 0",
               ex_valid_o, ex_memread_o, ex_rd_o, ex_imm32_o);
    end
    flush_i = 0; stall_i = 0;
    clr_id();
    id_valid_i = 1; id_rd_i = 10; id_imm32_i = 32'h55;
    id_regwrite_i = 1;
    tick();
    n_vec++;
    if (ex_valid_o !== 1 || ex_rd_o !== 10 || ex_imm32_o !== 32'h55) begin
      n_err++;
      $display("FAIL post_flush: v=%b rd=%0d imm=%h want 1 10 55",
               ex_valid_o, ex_rd_o, ex_imm32_o);
    end
    stall_i = 1;
    #2;
    rst_n = 0;
    #1;
    n_vec++;
    if (ex_valid_o !== 0 || ex_rd_o !== 0 || ex_imm32_o !== 0
        || ex_regwrite_o !== 0) begin
      n_err++;
      $display("FAIL async_reset: v=%b rd=%0d imm=%h want 0",
               ex_valid_o, ex_rd_o, ex_imm32_o);
    end
    stall_i = 0;
    tick();
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_stall_recapture();
    test_flush_over_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
